// File: rtl/serial_magnitude_compare_ctrl.sv
// serial_magnitude_compare_ctrl: compares two W-bit operands nibble by
// nibble through one shared external 4-bit comparator, MSB nibble first.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start, a, b         request pulse and operands (captured on accept)
//   busy, done          in-progress flag, one-cycle completion pulse
//   eq, lt, gt          registered result, held until next accept
//   cmp_a, cmp_b        registered nibbles driven to the comparator
//   cmp_eq/lt/gt        comparator results, sampled the same cycle
//
// Optional feature macro: SERIAL_CMP_SIGNED_EN (two's complement order
// by flipping bit 3 of the most-significant nibble pair).
module serial_magnitude_compare_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic               busy,
  output logic               done,
  output logic               eq,
  output logic               lt,
  output logic               gt,
  output logic [3:0]         cmp_a,
  output logic [3:0]         cmp_b,
  input  logic               cmp_eq,
  input  logic               cmp_lt,
  input  logic               cmp_gt
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] TOP = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] idx, idx_d, idx_m1;
  logic [W-1:0]  opa, opa_d;
  logic [W-1:0]  opb, opb_d;
  logic [3:0]    cmp_a_d, cmp_b_d;
  logic          eq_d, lt_d, gt_d;
  logic [3:0]    msn_a, msn_b;
  logic [3:0]    nxt_a, nxt_b;

  // Most-significant nibble goes straight from the inputs into the
  // comparator register on the accepting edge, so the first COMPARE
  // cycle already presents it.
`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned
  // order; only the top nibble carries the sign.
  assign msn_a = a[W-1 -: 4] ^ 4'b1000;
  assign msn_b = b[W-1 -: 4] ^ 4'b1000;
`else
  assign msn_a = a[W-1 -: 4];
  assign msn_b = b[W-1 -: 4];
`endif

  // Lower nibbles are never the top one, so no inversion here.
  assign idx_m1 = idx - IW'(1);
  assign nxt_a  = opa[{idx_m1, 2'b00} +: 4];
  assign nxt_b  = opb[{idx_m1, 2'b00} +: 4];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    opa_d   = opa;
    opb_d   = opb;
    cmp_a_d = 4'h0;
    cmp_b_d = 4'h0;
    eq_d    = eq;
    lt_d    = lt;
    gt_d    = gt;
    unique case (state)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          idx_d   = TOP;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          cmp_a_d = msn_a;
          cmp_b_d = msn_b;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (cmp_eq) begin
          if (idx != '0) begin
            idx_d   = idx_m1;
            cmp_a_d = nxt_a;
            cmp_b_d = nxt_b;
          end else begin
            eq_d    = 1'b1;
            state_d = DONE;
          end
        end else begin
          // An illegal lt==gt pair is latched unchanged.
          lt_d    = cmp_lt;
          gt_d    = cmp_gt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      opa   <= '0;
      opb   <= '0;
      cmp_a <= 4'h0;
      cmp_b <= 4'h0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      opa   <= opa_d;
      opb   <= opb_d;
      cmp_a <= cmp_a_d;
      cmp_b <= cmp_b_d;
      eq    <= eq_d;
      lt    <= lt_d;
      gt    <= gt_d;
    end
  end

endmodule

// File: doc/serial_magnitude_compare_ctrl.md
Name: serial_magnitude_compare_ctrl

Overview:
Sequencer that compares two wide unsigned operands using one shared external 4-bit magnitude comparator, one nibble per clock, most-significant nibble first.
- Stops early on the first unequal nibble.
- Returns registered eq/lt/gt with a done pulse.
- Sits between a requesting datapath and the shared 4-bit comparator instance; it owns the comparator's operand inputs.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 1..16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request pulse; sampled only when busy=0
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  single-cycle pulse, results valid
eq  output  1  registered result A==B
lt  output  1  registered result A<B
gt  output  1  registered result A>B
cmp_a  output  4  nibble of A driven to shared comparator
cmp_b  output  4  nibble of B driven to shared comparator
cmp_eq  input  1  comparator equal result (combinational, same cycle)
cmp_lt  input  1  comparator less-than result
cmp_gt  input  1  comparator greater-than result

Behaviour:
- Reset (async, active-high): state=IDLE; busy, done, eq, lt, gt = 0; cmp_a = cmp_b = 0; index = 0; operand registers = 0.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 at a clock edge: latch a, b; index=NIBBLES-1; clear eq/lt/gt; go COMPARE.
  - start=0: stay in IDLE.
- COMPARE:
  - cmp_a/cmp_b = latched nibble [4*index+3 : 4*index], driven from registers (glitch-free); cmp_* results are sampled at the same edge.
  - cmp_eq=1 and index>0: index decrements; stay in COMPARE.
  - cmp_eq=1 and index=0: eq<=1; go DONE.
  - cmp_eq=0: lt<=cmp_lt, gt<=cmp_gt; go DONE.
  - cmp_eq=0 with cmp_lt=cmp_gt: protocol violation; latch values as-is (flagged by bench assertion, not RTL).
- DONE: done=1 for exactly one cycle; go IDLE.
- eq/lt/gt hold their value until the next accepted start clears them; exactly one is high after any legal completion.
- busy=1 in COMPARE and DONE.
- start is ignored while busy=1; no queuing. A start present in the DONE cycle is also ignored; a new start is accepted only in IDLE.
- Latency: with k nibbles examined (1..NIBBLES), done is high in the cycle following k COMPARE cycles, i.e. k+1 cycles after the accepting edge. Worst case NIBBLES+1; back-to-back throughput is one comparison per NIBBLES+2 cycles.
- cmp_a/cmp_b are 0 in IDLE and DONE.
- Async reset mid-COMPARE: immediate return to IDLE with all outputs 0; no done pulse.
- Operand inputs a/b may change freely after the accepting edge; only latched copies are used.

Optional Feature:
Macro SERIAL_CMP_SIGNED_EN.
- Defined: operands are treated as W-bit two's complement. For the most-significant nibble only, bit 3 of both cmp_a and cmp_b is inverted before driving the comparator, so the unsigned comparator yields the signed order. Lower nibbles are unchanged, and results keep the same eq/lt/gt meaning.
- Undefined: pure unsigned comparison, no inversion logic present.

Test Plan (NIBBLES=4):
- a=16'h1234, b=16'h1234, start pulse -> cmp_a sequence 1,2,3,4; eq=1, lt=gt=0; done high 5 cycles after accepting edge; busy high 5 cycles.
- a=16'h8000, b=16'h7FFF, unsigned build -> one compare; gt=1; done 2 cycles after accepting edge. Same stimulus with SERIAL_CMP_SIGNED_EN -> lt=1, done 2 cycles after.
- a=16'h12A4, b=16'h12B4 -> three compares (cmp_a 1,2,A); lt=1; done 4 cycles after accepting edge; cmp_a=cmp_b=0 in the done cycle.
- Accept a=16'h0001, b=16'h0000; assert start with a=b=16'hFFFF each cycle while busy and during done -> ignored; result gt=1; next start accepted only in IDLE.
- Start a=16'h1111, b=16'h1111; assert rst during the 2nd COMPARE cycle -> busy, done, eq, lt, gt, cmp_a all 0 immediately; after release, new start a=16'h0002, b=16'h0003 -> lt=1 after 5 cycles.
